demux_dispatcher: RTL and testbench

- Upstream feeder for the 2-bit 1-to-4 demultiplexer.
- Accepts a stream of {destination, data} words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents one word at a time on the demux A/SEL inputs through a registered output stage.
- Keeps a wrapping transfer count per destination (W/X/Y/Z = SEL 0/1/2/3).

---
 rtl/demux_dispatcher.sv | 141 ++++++++++++++
 tb/tb_demux_dispatcher.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: buffers {dest, data} words in a small FIFO and feeds them one
// at a time to the 1-to-4 demux through a registered A/SEL stage, counting
// transfers per destination.
module demux_dispatcher #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [1:0]                   IN_DATA,
    input  logic [1:0]                   IN_DEST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [1:0]                   A,
    output logic [1:0]                   SEL,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    input  logic                         FLUSH,
    input  logic [1:0]                   COUNT_SEL,
    output logic [CNT_W-1:0]             COUNT,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
    output logic                         FULL,
    output logic                         EMPTY
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [1:0] dest;
        logic [1:0] data;
    } word_t;

    word_t            r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [1:0]       r_a;
    logic [1:0]       r_sel;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt [4];

    logic  w_full;
    logic  w_fifo_empty;
    logic  w_push;
    logic  w_xfer;
    logic  w_load;
    logic  w_pop;
    logic  w_bypass;
    logic  w_fifo_wr;
    word_t w_in_word;
    word_t w_head;

    assign w_full       = (r_level == LW'(DEPTH));
    assign w_fifo_empty = (r_level == LW'(0));
    assign w_in_word    = '{dest: IN_DEST, data: IN_DATA};
    assign w_head       = r_mem[r_rd_ptr];

    // Handshake decode: output stage reloads when empty or draining; bypass skips an empty FIFO.
    assign w_push    = IN_VALID && IN_READY;
    assign w_xfer    = r_out_valid && OUT_READY;
    assign w_load    = !r_out_valid || w_xfer;
    assign w_pop     = w_load && !w_fifo_empty;
    assign w_bypass  = w_load && w_fifo_empty && w_push;
    assign w_fifo_wr = w_push && !w_bypass && !FLUSH;

    // Ready depends only on registered occupancy, held low while in reset.
    assign IN_READY  = RST_N && !w_full;
    assign A         = r_a;
    assign SEL       = r_sel;
    assign OUT_VALID = r_out_valid;
    assign COUNT     = r_cnt[COUNT_SEL];
    assign LEVEL     = r_level;
    assign FULL      = w_full;
    assign EMPTY     = w_fifo_empty && !r_out_valid;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
    end

    // Pointers, occupancy and the registered output stage; FLUSH overrides everything here.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_a         <= '0;
            r_sel       <= '0;
            r_out_valid <= 1'b0;
        end else if (FLUSH) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_a         <= '0;
            r_sel       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_fifo_wr && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_fifo_wr) begin
                r_level <= r_level - LW'(1);
            end
            if (w_load) begin
                if (w_pop) begin
                    r_a         <= w_head.data;
                    r_sel       <= w_head.dest;
                    r_out_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_a         <= IN_DATA;
                    r_sel       <= IN_DEST;
                    r_out_valid <= 1'b1;
                end else begin
                    r_a         <= '0;
                    r_sel       <= '0;
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    // Per-destination transfer counters; a transfer seen by the consumer counts even during FLUSH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_xfer) begin
            r_cnt[r_sel] <= r_cnt[r_sel] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: a queue holds every word inside the
// dispatcher (FIFO plus output register); flags, A/SEL and counters are derived from it.
module tb_demux_dispatcher;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LW    = $clog2(DEPTH+1);

    logic             CLK;
    logic             RST_N;
    logic [1:0]       IN_DATA;
    logic [1:0]       IN_DEST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       A;
    logic [1:0]       SEL;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             FLUSH;
    logic [1:0]       COUNT_SEL;
    logic [CNT_W-1:0] COUNT;
    logic [LW-1:0]    LEVEL;
    logic             FULL;
    logic             EMPTY;

    logic [3:0]       sb_q [$];
    logic [CNT_W-1:0] cnt_m [4];
    int               n_checks;
    int               n_fail;

    demux_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_DATA   (IN_DATA),
        .IN_DEST   (IN_DEST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .SEL       (SEL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .FLUSH     (FLUSH),
        .COUNT_SEL (COUNT_SEL),
        .COUNT     (COUNT),
        .LEVEL     (LEVEL),
        .FULL      (FULL),
        .EMPTY     (EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare occupancy flags and A/SEL against the scoreboard contents.
    task automatic check_state();
        int         sz;
        logic [3:0] head;
        sz = sb_q.size();
        chk("in_ready",  32'(IN_READY),  32'(sz <= int'(DEPTH)));
        chk("out_valid", 32'(OUT_VALID), 32'(sz > 0));
        chk("level",     32'(LEVEL),     32'((sz > 0) ? sz - 1 : 0));
        chk("full",      32'(FULL),      32'(sz == int'(DEPTH) + 1));
        chk("empty",     32'(EMPTY),     32'(sz == 0));
        if (sz > 0) begin
            head = sb_q[0];
            chk("a",   32'(A),   32'(head[1:0]));
            chk("sel", 32'(SEL), 32'(head[3:2]));
        end else begin
            chk("a_sel_idle", 32'({SEL, A}), 32'(0));
        end
    endtask

    // Walk COUNT_SEL through all destinations and compare COUNT.
    task automatic check_counts();
        for (int i = 0; i < 4; i++) begin
            COUNT_SEL = 2'(i);
            #1;
            chk($sformatf("count%0d", i), 32'(COUNT), 32'(cnt_m[i]));
        end
    endtask

    // One clock: drive at negedge, check, then update the model at the posedge.
    task automatic cycle(input logic v, input logic [1:0] data, input logic [1:0] dest,
                         input logic ordy, input logic fl);
        logic       xfer;
        logic       push;
        logic [3:0] w;
        @(negedge CLK);
        IN_VALID  = v;
        IN_DATA   = data;
        IN_DEST   = dest;
        OUT_READY = ordy;
        FLUSH     = fl;
        #1;
        check_state();
        xfer = (sb_q.size() > 0) && ordy;
        push = v && (sb_q.size() <= int'(DEPTH));
        @(posedge CLK);
        if (xfer) begin
            w = sb_q.pop_front();
            cnt_m[w[3:2]] = cnt_m[w[3:2]] + CNT_W'(1);
        end
        if (fl) begin
            sb_q.delete();
        end else if (push) begin
            sb_q.push_back({dest, data});
        end
    endtask

    // Asynchronous reset asserted mid-cycle; state must clear without a clock edge.
    task automatic async_reset();
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        sb_q.delete();
        for (int i = 0; i < 4; i++) cnt_m[i] = '0;
        chk("rst_in_ready",  32'(IN_READY),   32'(0));
        chk("rst_out_valid", 32'(OUT_VALID),  32'(0));
        chk("rst_level",     32'(LEVEL),      32'(0));
        chk("rst_full",      32'(FULL),       32'(0));
        chk("rst_empty",     32'(EMPTY),      32'(1));
        chk("rst_a_sel",     32'({SEL, A}),   32'(0));
        check_counts();
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    logic [1:0] bp_data [6];
    logic [1:0] bp_dest [6];

    initial begin
        CLK       = 1'b0;
        RST_N     = 1'b0;
        IN_DATA   = '0;
        IN_DEST   = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        FLUSH     = 1'b0;
        COUNT_SEL = '0;
        n_checks  = 0;
        n_fail    = 0;
        bp_data   = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
        bp_dest   = '{2'd0,  2'd1,  2'd3,  2'd2,  2'd0,  2'd1};

        // Power-on reset
        async_reset();

        // Single word to Y with the consumer ready
        cycle(1'b1, 2'b01, 2'd2, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        check_counts();

        // Backpressure fill: sixth word refused, then drain in order
        for (int i = 0; i < 6; i++) cycle(1'b1, bp_data[i], bp_dest[i], 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        check_counts();

        // Full with a simultaneous pop: push blocked, level drops, ready returns
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 2'd3, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        check_counts();

        // FLUSH with three buffered words and a simultaneous push
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0, 1'b0);
        cycle(1'b1, 2'b11, 2'd1, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        check_counts();

        // FLUSH coinciding with a transfer still counts the transfer
        for (int i = 0; i < 2; i++) cycle(1'b1, 2'b10, 2'd2, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        check_counts();

        // Asynchronous reset with LEVEL=2, then normal operation resumes
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        async_reset();
        cycle(1'b1, 2'b10, 2'd1, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        check_counts();

        // Counter wrap: 256 back-to-back words to Z
        for (int i = 0; i < 256; i++) cycle(1'b1, 2'($urandom_range(3)), 2'd3, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
        check_counts();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
